// File: rtl/lcd_timing_gen.sv
// Parallel-RGB LCD timing generator with a prefetching pixel request interface.
// Define LCD_TEST_PATTERN_EN to add test_en, which swaps pixel_in for 8 vertical colour bars.

module lcd_timing_gen #(
  parameter int unsigned H_SYNC   = 11,
  parameter int unsigned H_BP     = 35,
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned H_FP     = 210,
  parameter int unsigned V_SYNC   = 10,
  parameter int unsigned V_BP     = 13,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 23,
  parameter int unsigned PREFETCH = 1,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0
) (
  input  logic                        Dclk,
  input  logic                        reset,
`ifdef LCD_TEST_PATTERN_EN
  input  logic                        test_en,
`endif
  input  logic [23:0]                 pixel_in,
  output logic                        req,
  output logic [$clog2(H_ACTIVE)-1:0] x,
  output logic [$clog2(V_ACTIVE)-1:0] y,
  output logic [7:0]                  lcd_r,
  output logic [7:0]                  lcd_g,
  output logic [7:0]                  lcd_b,
  output logic                        lcd_de,
  output logic                        lcd_hs,
  output logic                        lcd_vs,
  output logic                        lcd_dclk,
  output logic                        frame_start,
  output logic                        line_start
);

  localparam int unsigned HTotal = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int unsigned VTotal = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int unsigned HW     = $clog2(HTotal + 1);
  localparam int unsigned VW     = $clog2(VTotal + 1);
  localparam int unsigned XW     = $clog2(H_ACTIVE);
  localparam int unsigned YW     = $clog2(V_ACTIVE);
  // Requests lead the first active column by the source latency plus the output register.
  localparam int unsigned Req0   = H_SYNC + H_BP - PREFETCH - 1;

  localparam logic [HW-1:0] HMax       = HW'(HTotal - 1);
  localparam logic [HW-1:0] ReqStart   = HW'(Req0);
  localparam logic [HW-1:0] ReqEnd     = HW'(Req0 + H_ACTIVE);
  localparam logic [HW-1:0] HSyncEnd   = HW'(H_SYNC);
  localparam logic [VW-1:0] VMax       = VW'(VTotal - 1);
  localparam logic [VW-1:0] VActStart  = VW'(V_SYNC + V_BP);
  localparam logic [VW-1:0] VActEnd    = VW'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [VW-1:0] VSyncEnd   = VW'(V_SYNC);

  logic [HW-1:0]       h_cnt_q, h_cnt_d;
  logic [VW-1:0]       v_cnt_q, v_cnt_d;
  logic                req_q, req_d;
  logic [XW-1:0]       x_q, x_d;
  logic [YW-1:0]       y_q, y_d;
  logic [PREFETCH-1:0] vld_q;
  logic                de_q;
  logic [23:0]         rgb_q, rgb_d;
  logic                hs_q, hs_d;
  logic                vs_q, vs_d;
  logic                line_act_d;

`ifdef LCD_TEST_PATTERN_EN
  logic [XW-1:0] x_pipe_q [PREFETCH];
  logic [2:0]    bar;

  // Column index travels alongside the valid pipe so the bar matches the pixel slot.
  always_ff @(posedge Dclk) begin
    if (reset) begin
      for (int k = 0; k < PREFETCH; k++) x_pipe_q[k] <= '0;
    end else begin
      x_pipe_q[0] <= x_q;
      for (int k = 1; k < PREFETCH; k++) x_pipe_q[k] <= x_pipe_q[k-1];
    end
  end

  always_comb bar = 3'((32'(x_pipe_q[PREFETCH-1]) * 32'd8) / H_ACTIVE);
`endif

  always_comb begin
    h_cnt_d = h_cnt_q + HW'(1);
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == HMax) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == VMax) ? '0 : v_cnt_q + VW'(1);
    end

    line_act_d = (v_cnt_d >= VActStart) && (v_cnt_d < VActEnd);
    req_d      = line_act_d && (h_cnt_d >= ReqStart) && (h_cnt_d < ReqEnd);
    x_d        = req_d ? XW'(h_cnt_d - ReqStart) : x_q;
    y_d        = req_d ? YW'(v_cnt_d - VActStart) : y_q;

    hs_d = (h_cnt_d < HSyncEnd) ? HS_POL : ~HS_POL;
    vs_d = (v_cnt_d < VSyncEnd) ? VS_POL : ~VS_POL;

    rgb_d = '0;
    if (vld_q[PREFETCH-1]) begin
`ifdef LCD_TEST_PATTERN_EN
      if (test_en) rgb_d = {{8{bar[2]}}, {8{bar[1]}}, {8{bar[0]}}};
      else         rgb_d = pixel_in;
`else
      rgb_d = pixel_in;
`endif
    end
  end

  always_ff @(posedge Dclk) begin
    if (reset) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      req_q   <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      vld_q   <= '0;
      de_q    <= 1'b0;
      rgb_q   <= '0;
      hs_q    <= ~HS_POL;
      vs_q    <= ~VS_POL;
    end else begin
      h_cnt_q  <= h_cnt_d;
      v_cnt_q  <= v_cnt_d;
      req_q    <= req_d;
      x_q      <= x_d;
      y_q      <= y_d;
      vld_q[0] <= req_q;
      for (int k = 1; k < PREFETCH; k++) vld_q[k] <= vld_q[k-1];
      de_q     <= vld_q[PREFETCH-1];
      rgb_q    <= rgb_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
    end
  end

  assign req         = req_q;
  assign x           = x_q;
  assign y           = y_q;
  assign lcd_r       = rgb_q[23:16];
  assign lcd_g       = rgb_q[15:8];
  assign lcd_b       = rgb_q[7:0];
  assign lcd_de      = de_q;
  assign lcd_hs      = hs_q;
  assign lcd_vs      = vs_q;
  assign lcd_dclk    = Dclk;
  // Gated so the zeroed counters held in reset do not look like a frame boundary.
  assign frame_start = ~reset & (h_cnt_q == '0) & (v_cnt_q == '0);
  assign line_start  = ~reset & (h_cnt_q == '0);

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Scoreboard bench for lcd_timing_gen: default timing (PREFETCH=3), a tiny frame and inverted syncs.
module tb_lcd_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic test_en;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [23:0] rgb;
    int unsigned due;
    int unsigned xv;
  } exp_t;
  exp_t sb_q[$];

  // Default timing, PREFETCH=3
  logic d_req, d_de, d_hs, d_vs, d_dclk, d_fs, d_ls;
  logic [9:0] d_x;
  logic [8:0] d_y;
  logic [7:0] d_r, d_g, d_b;
  logic [23:0] d_pix;
  // Tiny frame: H 2/2/4/2, V 1/1/2/1, PREFETCH=1
  logic s_req, s_de, s_hs, s_vs, s_dclk, s_fs, s_ls;
  logic [1:0] s_x;
  logic [0:0] s_y;
  logic [7:0] s_r, s_g, s_b;
  logic [23:0] s_pix;
  // Inverted syncs: H 3/2/4/2, V 3/1/2/1, PREFETCH=2
  logic p_req, p_de, p_hs, p_vs, p_dclk, p_fs, p_ls;
  logic [1:0] p_x;
  logic [0:0] p_y;
  logic [7:0] p_r, p_g, p_b;
  logic [23:0] p_pix;

  lcd_timing_gen #(.PREFETCH(3)) u_def (
    .Dclk(clk), .reset(reset),
`ifdef LCD_TEST_PATTERN_EN
    .test_en(test_en),
`endif
    .pixel_in(d_pix), .req(d_req), .x(d_x), .y(d_y), .lcd_r(d_r), .lcd_g(d_g), .lcd_b(d_b),
    .lcd_de(d_de), .lcd_hs(d_hs), .lcd_vs(d_vs), .lcd_dclk(d_dclk), .frame_start(d_fs),
    .line_start(d_ls)
  );

  lcd_timing_gen #(
    .H_SYNC(2), .H_BP(2), .H_ACTIVE(4), .H_FP(2), .V_SYNC(1), .V_BP(1), .V_ACTIVE(2), .V_FP(1),
    .PREFETCH(1)
  ) u_small (
    .Dclk(clk), .reset(reset),
`ifdef LCD_TEST_PATTERN_EN
    .test_en(1'b0),
`endif
    .pixel_in(s_pix), .req(s_req), .x(s_x), .y(s_y), .lcd_r(s_r), .lcd_g(s_g), .lcd_b(s_b),
    .lcd_de(s_de), .lcd_hs(s_hs), .lcd_vs(s_vs), .lcd_dclk(s_dclk), .frame_start(s_fs),
    .line_start(s_ls)
  );

  lcd_timing_gen #(
    .H_SYNC(3), .H_BP(2), .H_ACTIVE(4), .H_FP(2), .V_SYNC(3), .V_BP(1), .V_ACTIVE(2), .V_FP(1),
    .PREFETCH(2), .HS_POL(1'b1), .VS_POL(1'b1)
  ) u_pol (
    .Dclk(clk), .reset(reset),
`ifdef LCD_TEST_PATTERN_EN
    .test_en(1'b0),
`endif
    .pixel_in(p_pix), .req(p_req), .x(p_x), .y(p_y), .lcd_r(p_r), .lcd_g(p_g), .lcd_b(p_b),
    .lcd_de(p_de), .lcd_hs(p_hs), .lcd_vs(p_vs), .lcd_dclk(p_dclk), .frame_start(p_fs),
    .line_start(p_ls)
  );

  function automatic logic [23:0] code_d(input logic [9:0] xx, input logic [8:0] yy);
    return {xx[7:0], 5'b10101, xx[9:8], yy};
  endfunction
  function automatic logic [23:0] code_s(input logic [1:0] xx, input logic [0:0] yy);
    return {6'h2A, xx, 7'h11, yy, 8'h3C};
  endfunction
  function automatic logic [23:0] bar_rgb(input int unsigned xx);
    int unsigned b;
    b = (xx * 8) / 800;
    return {{8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
  endfunction

  // Pixel sources: answer each request PREFETCH cycles later, garbage otherwise.
  logic       d_hr [4];
  logic [9:0] d_hx [4];
  logic [8:0] d_hy [4];
  logic       s_hr [2];
  logic [1:0] s_hx [2];
  logic [0:0] s_hy [2];
  logic       p_hr [3];
  logic [1:0] p_hx [3];
  logic [0:0] p_hy [3];
  initial begin
    d_pix = '0; s_pix = '0; p_pix = '0;
    for (int i = 0; i < 4; i++) begin d_hr[i] = 1'b0; d_hx[i] = '0; d_hy[i] = '0; end
    for (int i = 0; i < 2; i++) begin s_hr[i] = 1'b0; s_hx[i] = '0; s_hy[i] = '0; end
    for (int i = 0; i < 3; i++) begin p_hr[i] = 1'b0; p_hx[i] = '0; p_hy[i] = '0; end
    forever begin
      @(posedge clk);
      #1;
      for (int i = 3; i > 0; i--) begin
        d_hr[i] = d_hr[i-1]; d_hx[i] = d_hx[i-1]; d_hy[i] = d_hy[i-1];
      end
      d_hr[0] = d_req; d_hx[0] = d_x; d_hy[0] = d_y;
      d_pix = d_hr[3] ? code_d(d_hx[3], d_hy[3]) : 24'($urandom);
      s_hr[1] = s_hr[0]; s_hx[1] = s_hx[0]; s_hy[1] = s_hy[0];
      s_hr[0] = s_req; s_hx[0] = s_x; s_hy[0] = s_y;
      s_pix = s_hr[1] ? code_s(s_hx[1], s_hy[1]) : 24'($urandom);
      for (int i = 2; i > 0; i--) begin
        p_hr[i] = p_hr[i-1]; p_hx[i] = p_hx[i-1]; p_hy[i] = p_hy[i-1];
      end
      p_hr[0] = p_req; p_hx[0] = p_x; p_hy[0] = p_y;
      p_pix = p_hr[2] ? code_s(p_hx[2], p_hy[2]) : 24'($urandom);
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({d_req, d_de, d_r, d_g, d_b, d_hs, d_vs, d_fs, d_ls, d_x, d_y} !==
          {2'b00, 24'h0, 2'b11, 2'b00, 19'h0}) begin
        n_err++;
        $display("FAIL rst_def: got %h want %h", {d_req, d_de, d_r, d_g, d_b, d_hs, d_vs,
                 d_fs, d_ls, d_x, d_y}, {2'b00, 24'h0, 2'b11, 2'b00, 19'h0});
      end
      n_cmp++;
      if ({p_req, p_de, p_r, p_g, p_b, p_hs, p_vs, p_fs, p_ls, p_x, p_y} !== 33'h0) begin
        n_err++;
        $display("FAIL rst_pol: got %h want 0", {p_req, p_de, p_r, p_g, p_b, p_hs, p_vs,
                 p_fs, p_ls, p_x, p_y});
      end
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({d_fs, d_ls, s_fs, p_fs} !== 4'hF) begin
      n_err++;
      $display("FAIL rst_release_fs: got %b want 1111", {d_fs, d_ls, s_fs, p_fs});
    end
    @(negedge clk);
    n_cmp++;
    if ({d_fs, d_ls} !== 2'b00) begin
      n_err++;
      $display("FAIL rst_fs_pulse: got %b want 00", {d_fs, d_ls});
    end
  endtask

  // Starts at h=1 of line 0; VSync must stay low for exactly 10 lines of 1056 cycles.
  task automatic test_def_vsync();
    int low_lines = 0;
    int k;
    if (d_vs === 1'b0) low_lines++;
    for (int ln = 1; ln < 12; ln++) begin
      k = 0;
      while (d_ls !== 1'b1 && k < 1100) begin @(negedge clk); k++; end
      n_cmp++;
      if (k != 1055) begin
        n_err++;
        $display("FAIL def_line_period: got %0d want 1055 cycles to line_start", k);
      end
      @(negedge clk);
      if (d_vs === 1'b0) low_lines++;
    end
    n_cmp++;
    if (low_lines != 10) begin
      n_err++;
      $display("FAIL def_vs_lines: got %0d want 10", low_lines);
    end
  endtask

  task automatic test_def_line();
    int k = 0;
    int first_req, first_de, n_req, n_de, n_hs, x_exp, y0;
    exp_t e;
    while (d_req !== 1'b1 && k < 30000) begin @(negedge clk); k++; end
    n_cmp++;
    if (k >= 30000) begin n_err++; $display("FAIL def_req_timeout: got none want req"); end
    k = 0;
    while (d_ls !== 1'b1 && k < 1100) begin @(negedge clk); k++; end
    sb_q.delete();
    y0 = -1;
    for (int ln = 0; ln < 2; ln++) begin
      n_cmp++;
      if (d_ls !== 1'b1) begin n_err++; $display("FAIL def_ls: got %b want 1", d_ls); end
      first_req = -1; first_de = -1; n_req = 0; n_de = 0; n_hs = 0; x_exp = 0;
      for (int h = 0; h < 1056; h++) begin
        if (d_req === 1'b1) begin
          if (first_req < 0) first_req = h;
          if (int'(d_x) == x_exp) n_req++;
          x_exp++;
          if (ln == 0 && y0 < 0) y0 = int'(d_y);
          if (ln == 1 && h == first_req) begin
            n_cmp++;
            if (int'(d_y) != y0 + 1) begin
              n_err++;
              $display("FAIL def_y_step: got %0d want %0d", d_y, y0 + 1);
            end
          end
          sb_q.push_back('{rgb: code_d(d_x, d_y), due: cyc + 4, xv: d_x});
        end
        if (d_de === 1'b1) begin
          if (first_de < 0) first_de = h;
          n_de++;
          n_cmp++;
          if (sb_q.size() == 0) begin
            n_err++;
            $display("FAIL def_sb_empty: got lcd_de want no data");
          end else begin
            e = sb_q.pop_front();
            if ({d_r, d_g, d_b} !== e.rgb || cyc != e.due) begin
              n_err++;
              $display("FAIL def_pixel: got %h@%0d want %h@%0d", {d_r, d_g, d_b}, cyc,
                       e.rgb, e.due);
            end
          end
        end else begin
          n_cmp++;
          if ({d_r, d_g, d_b} !== 24'h0) begin
            n_err++;
            $display("FAIL def_rgb_blank: got %h want 000000", {d_r, d_g, d_b});
          end
        end
        if (d_hs === 1'b0) n_hs++;
        @(negedge clk);
      end
      n_cmp++;
      if ({first_req, first_de, n_req, n_de, n_hs} !== {32'd42, 32'd46, 32'd800, 32'd800, 32'd11})
      begin
        n_err++;
        $display("FAIL def_line: got req@%0d de@%0d x_ok=%0d de=%0d hs=%0d want 42 46 800 800 11",
                 first_req, first_de, n_req, n_de, n_hs);
      end
    end
    n_cmp++;
    if (d_ls !== 1'b1) begin n_err++; $display("FAIL def_ls_end: got %b want 1", d_ls); end
  endtask

`ifdef LCD_TEST_PATTERN_EN
  task automatic test_pattern();
    exp_t e;
    int spots = 0;
    sb_q.delete();
    test_en = 1'b1;
    for (int h = 0; h < 1056; h++) begin
      if (d_req === 1'b1) sb_q.push_back('{rgb: bar_rgb(d_x), due: cyc + 4, xv: d_x});
      if (d_de === 1'b1 && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_cmp++;
        if ({d_r, d_g, d_b} !== e.rgb) begin
          n_err++;
          $display("FAIL pat_bar x=%0d: got %h want %h", e.xv, {d_r, d_g, d_b}, e.rgb);
        end
        if (e.xv == 0 || e.xv == 100 || e.xv == 799) begin
          spots++;
          n_cmp++;
          if ({d_r, d_g, d_b} !== (e.xv == 0 ? 24'h000000 : e.xv == 100 ? 24'h0000FF : 24'hFFFFFF))
          begin
            n_err++;
            $display("FAIL pat_spot x=%0d: got %h", e.xv, {d_r, d_g, d_b});
          end
        end
      end
      @(negedge clk);
    end
    test_en = 1'b0;
    n_cmp++;
    if (spots != 3) begin n_err++; $display("FAIL pat_spots: got %0d want 3", spots); end
  endtask
`endif

  task automatic test_small_pipeline();
    int k = 0;
    int vl = 0;
    int x_exp = 0;
    int lc [5];
    exp_t e;
    while (s_fs !== 1'b1 && k < 100) begin @(negedge clk); k++; end
    n_cmp++;
    if (k >= 100) begin n_err++; $display("FAIL small_fs_timeout: got none want frame_start"); end
    sb_q.delete();
    for (int i = 0; i < 5; i++) lc[i] = 0;
    for (int t = 0; t <= 100; t++) begin
      if (t == 50 || t == 100) begin
        n_cmp++;
        if (s_fs !== 1'b1) begin n_err++; $display("FAIL small_frame_period: got 0 want fs"); end
        n_cmp++;
        if ({8'(lc[0]), 8'(lc[1]), 8'(lc[2]), 8'(lc[3]), 8'(lc[4])} !== 40'h00_00_04_04_00) begin
          n_err++;
          $display("FAIL small_de_lines: got %0d %0d %0d %0d %0d want 0 0 4 4 0",
                   lc[0], lc[1], lc[2], lc[3], lc[4]);
        end
        for (int i = 0; i < 5; i++) lc[i] = 0;
      end
      if (t == 100) break;
      if (s_fs === 1'b1) begin vl = 0; x_exp = 0; end
      else if (s_ls === 1'b1) begin vl++; x_exp = 0; end
      if (s_req === 1'b1) begin
        n_cmp++;
        if (int'(s_x) != x_exp) begin
          n_err++;
          $display("FAIL small_x_order: got %0d want %0d", s_x, x_exp);
        end
        x_exp++;
        sb_q.push_back('{rgb: code_s(s_x, s_y), due: cyc + 2, xv: s_x});
      end
      if (s_de === 1'b1) begin
        if (vl < 5) lc[vl]++;
        n_cmp++;
        if (sb_q.size() == 0) begin
          n_err++;
          $display("FAIL small_sb_empty: got lcd_de want no data");
        end else begin
          e = sb_q.pop_front();
          if ({s_r, s_g, s_b} !== e.rgb || cyc != e.due) begin
            n_err++;
            $display("FAIL small_pixel: got %h@%0d want %h@%0d", {s_r, s_g, s_b}, cyc,
                     e.rgb, e.due);
          end
        end
      end
      @(negedge clk);
    end
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL small_sb_left: got %0d want 0", sb_q.size());
    end
  endtask

  task automatic test_polarity();
    int k = 0;
    int ln = -1;
    int hpos = 0;
    int hs_hi = 0;
    int vs_hi = 0;
    int de_n = 0;
    while (p_fs !== 1'b1 && k < 100) begin @(negedge clk); k++; end
    for (int t = 0; t < 77; t++) begin
      if (p_ls === 1'b1) begin
        if (ln >= 0) begin
          n_cmp++;
          if (hs_hi != 3) begin
            n_err++;
            $display("FAIL pol_hs_width line %0d: got %0d want 3", ln, hs_hi);
          end
        end
        ln++; hs_hi = 0; hpos = 0;
      end else hpos++;
      if (p_hs === 1'b1) hs_hi++;
      if (hpos == 1 && p_vs === 1'b1) vs_hi++;
      if (p_de === 1'b1) de_n++;
      else begin
        n_cmp++;
        if ({p_r, p_g, p_b} !== 24'h0) begin
          n_err++;
          $display("FAIL pol_rgb_blank: got %h want 000000", {p_r, p_g, p_b});
        end
      end
      @(negedge clk);
    end
    n_cmp++;
    if ({ln, hs_hi, vs_hi, de_n, 31'd0, p_fs} !== {32'd6, 32'd3, 32'd3, 32'd8, 32'd1}) begin
      n_err++;
      $display("FAIL pol_frame: got lines=%0d hs=%0d vs=%0d de=%0d fs=%b want 6 3 3 8 1",
               ln, hs_hi, vs_hi, de_n, p_fs);
    end
  endtask

  task automatic test_midframe_reset();
    int k = 0;
    int de_n = 0;
    @(negedge clk);
    while (d_ls !== 1'b1 && k < 1100) begin @(negedge clk); k++; end
    repeat (500) @(negedge clk);
    n_cmp++;
    if (d_de !== 1'b1) begin n_err++; $display("FAIL mid_de_before: got %b want 1", d_de); end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({d_req, d_de, d_r, d_g, d_b, d_hs, d_vs, d_fs} !== {2'b00, 24'h0, 2'b11, 1'b0}) begin
        n_err++;
        $display("FAIL mid_idle: got %h want %h", {d_req, d_de, d_r, d_g, d_b, d_hs, d_vs, d_fs},
                 {2'b00, 24'h0, 2'b11, 1'b0});
      end
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if (d_fs !== 1'b1) begin n_err++; $display("FAIL mid_fs_after: got %b want 1", d_fs); end
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (d_de === 1'b1) de_n++;
    end while (d_ls !== 1'b1 && k < 1100);
    n_cmp++;
    if (k != 1056 || de_n != 0) begin
      n_err++;
      $display("FAIL mid_restart: got period %0d de %0d want 1056 0", k, de_n);
    end
  endtask

  initial begin
    reset = 1'b1;
    test_en = 1'b0;
    test_reset();
    test_def_vsync();
    test_def_line();
`ifdef LCD_TEST_PATTERN_EN
    test_pattern();
`endif
    test_small_pipeline();
    test_polarity();
    test_midframe_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lcd_timing_gen.md
LCD_TIMING_GEN -- requirements
Module: lcd_timing_gen

Interface
REQ-001 SHALL have parameter H_SYNC, default 11, HSync width in Dclk cycles.
REQ-002 SHALL have parameter H_BP, default 35, horizontal back porch in cycles.
REQ-003 SHALL have parameter H_ACTIVE, default 800, active pixels per line.
REQ-004 SHALL have parameter H_FP, default 210, horizontal front porch in cycles.
REQ-005 SHALL have parameter V_SYNC, default 10, VSync width in lines.
REQ-006 SHALL have parameter V_BP, default 13, vertical back porch in lines.
REQ-007 SHALL have parameter V_ACTIVE, default 480, active lines per frame.
REQ-008 SHALL have parameter V_FP, default 23, vertical front porch in lines.
REQ-009 SHALL have parameter PREFETCH, default 1, range 1..4, pixel-source latency in cycles.
REQ-010 SHALL have parameters HS_POL and VS_POL, default 0, active level of the syncs.
REQ-011 SHALL have ports Dclk in 1 (pixel clock; the only clock) and reset in 1 (synchronous, active-high).
REQ-012 SHALL have port pixel_in in 24, {R,G,B} for the requested pixel, valid PREFETCH cycles after req.
REQ-013 SHALL have outputs req 1 (pixel request), x XW = clog2(H_ACTIVE) (request column), y YW = clog2(V_ACTIVE) (request row).
REQ-014 SHALL have outputs lcd_r, lcd_g, lcd_b 8 each, lcd_de 1, lcd_hs 1, lcd_vs 1, lcd_dclk 1 (= Dclk), frame_start 1, line_start 1.

Function
REQ-015 SHALL keep h_cnt in 0..H_TOTAL-1 (H_TOTAL = sum of the H parameters), incrementing every Dclk and wrapping to 0.
REQ-016 SHALL keep v_cnt in 0..V_TOTAL-1, incrementing only on an h_cnt wrap and wrapping to 0 at V_TOTAL-1; no derived clocks.
REQ-017 SHALL treat an active line as V_SYNC+V_BP <= v_cnt < V_SYNC+V_BP+V_ACTIVE.
REQ-018 SHALL treat an active column as HA0 <= h_cnt < HA0+H_ACTIVE, with HA0 = H_SYNC+H_BP.
REQ-019 SHALL assert req on active lines for exactly H_ACTIVE consecutive cycles, starting at h_cnt = HA0-PREFETCH-1, with x = 0..H_ACTIVE-1 ascending and y = active line index.
REQ-020 SHALL register x and y with req; both hold their last value while req = 0.
REQ-021 SHALL sample pixel_in PREFETCH cycles after the matching req and drive lcd_r/g/b and lcd_de one cycle later, so lcd_de aligns with the active columns.
REQ-022 SHALL delay hs and vs through the same pipeline: lcd_hs = HS_POL while h_cnt < H_SYNC; lcd_vs = VS_POL while v_cnt < V_SYNC; otherwise the inverse level.
REQ-023 SHALL force lcd_r/g/b to 0 whenever lcd_de = 0.
REQ-024 SHALL pulse frame_start for one cycle when h_cnt = 0 and v_cnt = 0.
REQ-025 SHALL pulse line_start for one cycle when h_cnt = 0, on every line.
REQ-026 SHALL give lcd_de exactly H_ACTIVE*V_ACTIVE high cycles per frame.

Reset
REQ-027 SHALL on reset zero h_cnt, v_cnt, x, y, req, lcd_de and lcd_r/g/b, clear the pipeline, and drive lcd_hs/lcd_vs to their inactive levels.
REQ-028 SHALL on reset mid-frame abandon the frame; the first cycle after reset deasserts has h_cnt = 0, v_cnt = 0 and frame_start = 1.

Configuration
REQ-029 SHALL, with LCD_TEST_PATTERN_EN defined, add input test_en 1; when test_en = 1, lcd_r/g/b come from 8 vertical colour bars (bar = x*8/H_ACTIVE; bar bits {2,1,0} select R/G/B = 0xFF or 0x00, bar 0 black, bar 7 white), pixel_in is ignored and the timing is unchanged.
REQ-030 SHALL, without LCD_TEST_PATTERN_EN, omit test_en and always drive pixel data from pixel_in.

Verification
REQ-031 Defaults, 2 frames -> line period 1056 cycles; frame period 555456 cycles; 384000 lcd_de cycles per frame; lcd_hs low 11 cycles per line; lcd_vs low 10 lines.
REQ-032 H=2/2/4/2, V=1/1/2/1, PREFETCH=1, pixel_in = {x,y}-coded -> lcd_de high 4 cycles per active line; lcd_rgb matches the req x order with 2-cycle req-to-data latency.
REQ-033 PREFETCH=3, defaults -> first req at h_cnt = 42; first lcd_de at h_cnt = 46; x runs 0..799 with no gaps.
REQ-034 reset asserted at h_cnt = 500, v_cnt = 200 for 3 cycles -> outputs idle during reset; frame_start = 1 on the first cycle after release.
REQ-035 HS_POL=1, VS_POL=1 -> lcd_hs high 11 cycles; lcd_vs high 10 lines; rgb = 0 outside lcd_de.
REQ-036 LCD_TEST_PATTERN_EN with test_en = 1 -> x = 0 gives rgb 000000; x = 100 gives 0000FF; x = 799 gives FFFFFF.
